// File: rtl/nx_ram_arb_pkg.sv
// Shared types for the nx_ram_1rw hw-port arbiter.
//   arb_state_e : arbiter FSM states (init sweep, normal run)
//   rsp_tag_t   : read-response pipe entry {valid, requester id}
package nx_ram_arb_pkg;

  localparam int unsigned RSP_ID_W = 3;

  typedef enum logic {
    ARB_INIT,
    ARB_RUN
  } arb_state_e;

  typedef struct packed {
    logic                vld;
    logic [RSP_ID_W-1:0] id;
  } rsp_tag_t;

endpackage

// File: rtl/nx_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector, one bit per requester
//   ptr : highest-priority index for this cycle
//   gnt : one-hot grant (all zero when no request)
//   idx : encoded index of the granted requester
//   any : at least one request present
module nx_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [PW:0]      sum;

  always_comb begin
    // Rotate so that bit 0 is the requester at ptr; first set bit wins.
    rot = N_REQ'({req, req} >> ptr);
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (PW+1)'(i);
        if (sum >= (PW+1)'(N_REQ)) begin
          sum = sum - (PW+1)'(N_REQ);
        end
        idx = sum[PW-1:0];
      end
    end
    if (any) begin
      gnt = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/nx_ram_1rw_hw_arbiter.sv
// Shares the hw_* port of an nx_ram_1rw_indirect_access RAM among N_REQ
// requesters. After reset an optional sweep writes RESET_DATA to every entry,
// then requests are granted round-robin. Read responses are routed back to
// the issuing requester in issue order, RAM_LAT+2 cycles after accept.
// hw_yield limits back-to-back hw accesses so software accesses get a slot.
//   clk, rst_n         : clock, synchronous active-low reset
//   req_vld/we/addr/wdat : per-requester request (addr/wdat packed by index)
//   req_rdy            : combinational one-hot grant
//   rsp_vld, rsp_dat   : one-hot read response strobe and data
//   init_done          : init sweep finished
//   hw_add/we/bwe/cs/din : registered RAM port controls (bwe all-ones)
//   hw_dout            : RAM read data
//   hw_yield           : software access pending in the indirect controller
module nx_ram_1rw_hw_arbiter
  import nx_ram_arb_pkg::*;
#(
  parameter  int unsigned             N_REQ       = 4,
  parameter  int unsigned             N_DATA_BITS = 38,
  parameter  int unsigned             N_ENTRIES   = 16384,
  parameter  int unsigned             RAM_LAT     = 2,
  parameter  int unsigned             YIELD_MAX   = 4,
  parameter  int unsigned             INIT_EN     = 1,
  parameter  logic [N_DATA_BITS-1:0]  RESET_DATA  = '0,
  localparam int unsigned             AW          = $clog2(N_ENTRIES),
  localparam int unsigned             DW          = N_DATA_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_vld,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdat,
  output logic [N_REQ-1:0]    req_rdy,
  output logic [N_REQ-1:0]    rsp_vld,
  output logic [DW-1:0]       rsp_dat,
  output logic                init_done,
  output logic [AW-1:0]       hw_add,
  output logic                hw_we,
  output logic [DW-1:0]       hw_bwe,
  output logic                hw_cs,
  output logic [DW-1:0]       hw_din,
  input  logic [DW-1:0]       hw_dout,
  input  logic                hw_yield
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned YW = $clog2(YIELD_MAX + 1) + 1;

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]         init_addr_q, init_addr_d;
  logic [YW-1:0]         ycnt_q, ycnt_cur;
  logic                  hold;
  logic [RSP_ID_W-1:0]   iss_id_q, iss_id;
  logic                  iss_cs, iss_we;
  logic [AW-1:0]         iss_add;
  logic [DW-1:0]         iss_din;
  rsp_tag_t              pipe_q [RAM_LAT];

  logic [N_REQ-1:0]      arb_gnt;
  logic [PW-1:0]         arb_idx;
  logic                  arb_any;
  logic                  sel_we;
  logic [AW-1:0]         sel_add;
  logic [DW-1:0]         sel_din;

  assign hw_bwe = '1;

  nx_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req (req_vld),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Yield count including the current hw_cs cycle; stopping issue when it
  // reaches YIELD_MAX keeps the busy run at exactly YIELD_MAX cycles.
  always_comb begin
    ycnt_cur = '0;
    if (hw_cs) begin
      ycnt_cur = hw_yield ? (ycnt_q + 1'b1) : ycnt_q;
    end
    hold = (ycnt_cur == YW'(YIELD_MAX));
  end

  always_comb begin
    sel_we  = 1'b0;
    sel_add = '0;
    sel_din = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_we  = req_we[i];
        sel_add = req_addr[i*AW +: AW];
        sel_din = req_wdat[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_addr_d = init_addr_q;
    req_rdy     = '0;
    iss_cs      = 1'b0;
    iss_we      = 1'b0;
    iss_add     = '0;
    iss_din     = '0;
    iss_id      = '0;
    case (state_q)
      ARB_INIT: begin
        if (!hold) begin
          iss_cs  = 1'b1;
          iss_we  = 1'b1;
          iss_add = init_addr_q;
          iss_din = RESET_DATA;
          if (init_addr_q == AW'(N_ENTRIES - 1)) begin
            state_d     = ARB_RUN;
            init_addr_d = '0;
          end else begin
            init_addr_d = init_addr_q + 1'b1;
          end
        end
      end
      ARB_RUN: begin
        if (!hold && arb_any) begin
          req_rdy = arb_gnt;
          iss_cs  = 1'b1;
          iss_we  = sel_we;
          iss_add = sel_add;
          iss_din = sel_din;
          iss_id  = RSP_ID_W'(arb_idx);
          ptr_d   = (arb_idx == PW'(N_REQ - 1)) ? '0 : (arb_idx + 1'b1);
        end
      end
      default: begin
        state_d = ARB_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (INIT_EN != 0) ? ARB_INIT : ARB_RUN;
      ptr_q       <= '0;
      init_addr_q <= '0;
      ycnt_q      <= '0;
      hw_cs       <= 1'b0;
      hw_we       <= 1'b0;
      hw_add      <= '0;
      hw_din      <= '0;
      iss_id_q    <= '0;
      rsp_vld     <= '0;
      rsp_dat     <= '0;
      init_done   <= 1'b0;
      for (int unsigned i = 0; i < RAM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_addr_q <= init_addr_d;
      ycnt_q      <= ycnt_cur;
      hw_cs       <= iss_cs;
      hw_we       <= iss_we;
      hw_add      <= iss_add;
      hw_din      <= iss_din;
      iss_id_q    <= iss_id;
      init_done   <= (state_q == ARB_RUN);
      // Tag enters the pipe in the hw_cs cycle; its last stage lines up
      // with hw_dout being valid.
      pipe_q[0] <= '{vld: hw_cs & ~hw_we, id: iss_id_q};
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (pipe_q[RAM_LAT-1].vld) begin
        rsp_vld <= N_REQ'(1) << pipe_q[RAM_LAT-1].id;
        rsp_dat <= hw_dout;
      end else begin
        rsp_vld <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nx_ram_1rw_hw_arbiter.sv
// Directed self-checking bench for nx_ram_1rw_hw_arbiter (N_ENTRIES=16).
// A small behavioural RAM with two-cycle read latency sits on the hw port.
module tb_nx_ram_1rw_hw_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned DW    = 38;
  localparam int unsigned NE    = 16;
  localparam int unsigned AW    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdat;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    rsp_vld;
  logic [DW-1:0]       rsp_dat;
  logic                init_done;
  logic [AW-1:0]       hw_add;
  logic                hw_we;
  logic [DW-1:0]       hw_bwe;
  logic                hw_cs;
  logic [DW-1:0]       hw_din;
  logic [DW-1:0]       hw_dout;
  logic                hw_yield;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nx_ram_1rw_hw_arbiter #(
    .N_REQ       (N_REQ),
    .N_DATA_BITS (DW),
    .N_ENTRIES   (NE),
    .RAM_LAT     (2),
    .YIELD_MAX   (4),
    .INIT_EN     (1),
    .RESET_DATA  (38'h0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdat  (req_wdat),
    .req_rdy   (req_rdy),
    .rsp_vld   (rsp_vld),
    .rsp_dat   (rsp_dat),
    .init_done (init_done),
    .hw_add    (hw_add),
    .hw_we     (hw_we),
    .hw_bwe    (hw_bwe),
    .hw_cs     (hw_cs),
    .hw_din    (hw_din),
    .hw_dout   (hw_dout),
    .hw_yield  (hw_yield)
  );

  // RAM: read data valid two cycles after the hw_cs cycle.
  logic [DW-1:0] mem [NE];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (hw_cs) begin
      if (hw_we) mem[hw_add] <= hw_din;
      else       rd1 <= mem[hw_add];
    end
    rd2 <= rd1;
  end
  assign hw_dout = rd2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after reset release.
  task automatic init_sweep();
    req_vld = '1;
    req_we  = '0;
    #1;
    chk("init_rdy0", req_rdy, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("init_cs", hw_cs, 1);
      chk("init_we", hw_we, 1);
      chk("init_add", hw_add, k - 1);
      chk("init_din", hw_din, 0);
      chk("init_done_lo", init_done, 0);
      if (k <= 15) chk("init_rdy", req_rdy, 0);
      if (k == 15) req_vld = '0;
    end
    step();
    chk("init_done", init_done, 1);
    chk("post_init_cs", hw_cs, 0);
  endtask

  task automatic issue_wr(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_vld = N_REQ'(1) << id;
    req_we  = N_REQ'(1) << id;
    req_addr[id*AW +: AW] = a;
    req_wdat[id*DW +: DW] = d;
    #1;
    chk("wr_rdy", req_rdy, 1 << id);
    step();
    req_vld = '0;
    req_we  = '0;
    chk("wr_cs", hw_cs, 1);
    chk("wr_we", hw_we, 1);
    chk("wr_add", hw_add, a);
    chk("wr_din", hw_din, d);
  endtask

  task automatic issue_rd(input int id, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_vld = N_REQ'(1) << id;
    req_we  = '0;
    req_addr[id*AW +: AW] = a;
    #1;
    chk("rd_rdy", req_rdy, 1 << id);
    step();
    req_vld = '0;
    chk("rd_cs", hw_cs, 1);
    chk("rd_we", hw_we, 0);
    chk("rd_add", hw_add, a);
    step();
    chk("rd_rsp_t2", rsp_vld, 0);
    step();
    chk("rd_rsp_t3", rsp_vld, 0);
    step();
    chk("rd_rsp_vld", rsp_vld, 1 << id);
    chk("rd_rsp_dat", rsp_dat, exp);
    step();
    chk("rd_rsp_t5", rsp_vld, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    req_vld  = '0;
    req_we   = '0;
    req_addr = '0;
    req_wdat = '0;
    hw_yield = 1'b0;
    step();
    step();
    chk("rst_cs", hw_cs, 0);
    chk("rst_we", hw_we, 0);
    chk("rst_add", hw_add, 0);
    chk("rst_din", hw_din, 0);
    chk("rst_bwe", hw_bwe, 38'h3F_FFFF_FFFF);
    chk("rst_rsp", rsp_vld, 0);
    chk("rst_rdat", rsp_dat, 0);
    chk("rst_done", init_done, 0);
    chk("rst_rdy", req_rdy, 0);
    rst_n = 1'b1;

    // Init sweep
    init_sweep();

    // Round-robin reads, all requesters active
    req_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    req_we   = '0;
    req_vld  = '1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) req_vld = '0;
      #1;
      chk("rr_rdy", req_rdy, (k < 8) ? (1 << (k % 4)) : 0);
      chk("rr_rsp", rsp_vld, (k >= 4) ? (1 << ((k - 4) % 4)) : 0);
      if (k >= 1 && k <= 8) chk("rr_add", hw_add, ((k - 1) % 4) + 1);
      step();
    end

    // Write then read back, different requesters
    issue_wr(1, 4'd5, 38'h2A);
    issue_rd(0, 4'd5, 38'h2A);
    issue_wr(2, 4'd9, 38'h155);
    issue_rd(0, 4'd9, 38'h155);
    issue_wr(3, 4'd15, 38'h3F_FFFF_FFFF);
    issue_rd(1, 4'd15, 38'h3F_FFFF_FFFF);
    issue_rd(2, 4'd0, 38'h0);
    issue_rd(3, 4'd5, 38'h2A);

    // Yield: 4 busy cycles then one forced idle
    hw_yield = 1'b1;
    req_we   = '0;
    req_vld  = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("y_cs", hw_cs, (k >= 1) && (((k - 1) % 5) != 4));
      chk("y_rdy", |req_rdy, (k % 5) != 4);
      step();
    end
    req_vld  = '0;
    hw_yield = 1'b0;
    repeat (6) step();
    chk("y_drain", rsp_vld, 0);

    // Reset with two reads in flight, then reset mid-sweep at address 7
    req_vld = 4'b0011;
    #1;
    chk("t5_gnt0", |req_rdy, 1);
    step();
    chk("t5_gnt1", |req_rdy, 1);
    step();
    req_vld = '0;
    rst_n   = 1'b0;
    chk("t5_cs_inflight", hw_cs, 1);
    step();
    chk("t5_rst_cs", hw_cs, 0);
    chk("t5_rst_rsp", rsp_vld, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t5_sweep_cs", hw_cs, 1);
      chk("t5_sweep_add", hw_add, k - 1);
      chk("t5_no_rsp", rsp_vld, 0);
    end
    rst_n = 1'b0;
    step();
    chk("t5_rst2_cs", hw_cs, 0);
    rst_n = 1'b1;
    init_sweep();

    // Forced idle also applies to the init sweep
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    hw_yield = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("yi_cs", hw_cs, ((k - 1) % 5) != 4);
      if (((k - 1) % 5) != 4) chk("yi_add", hw_add, (k - 1) - (k - 1) / 5);
    end
    hw_yield = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
